// File: rtl/accel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accel_pkg
//  Description : Shared types and constants for the ADXL345 poll sequencer:
//                sequencer state encoding, fault codes, ADXL345 register map
//                and the bring-up configuration values.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package accel_pkg;

    typedef enum logic [3:0] {
        S_BOOT      = 4'd0,
        S_ID_ISSUE  = 4'd1,
        S_ID_WAIT   = 4'd2,
        S_CFG_ISSUE = 4'd3,
        S_CFG_WAIT  = 4'd4,
        S_IDLE      = 4'd5,
        S_RD_ISSUE  = 4'd6,
        S_RD_WAIT   = 4'd7,
        S_PUBLISH   = 4'd8,
        S_FAULT     = 4'd9
    } accel_seq_state_e;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'd0,
        FAULT_DEVID   = 2'd1,
        FAULT_TIMEOUT = 2'd2
    } accel_fault_e;

    // ADXL345 register map
    localparam logic [7:0] REG_DEVID       = 8'h00;
    localparam logic [7:0] REG_BW_RATE     = 8'h2C;
    localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
    localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
    localparam logic [7:0] REG_DATAX0      = 8'h32;

    // Bring-up values: 100 Hz output rate, full-resolution +/-16 g, measure mode
    localparam logic [7:0] CFG_BW_RATE     = 8'h0A;
    localparam logic [7:0] CFG_DATA_FORMAT = 8'h0B;
    localparam logic [7:0] CFG_POWER_CTL   = 8'h08;

    localparam logic [2:0] LAST_CFG_STEP   = 3'd2;
    localparam logic [2:0] LAST_DATA_STEP  = 3'd5;

    // {register address, write data} for configuration step 0..2
    function automatic logic [15:0] cfg_step_word(input logic [2:0] step);
        case (step)
            3'd0:    cfg_step_word = {REG_BW_RATE,     CFG_BW_RATE};
            3'd1:    cfg_step_word = {REG_DATA_FORMAT, CFG_DATA_FORMAT};
            default: cfg_step_word = {REG_POWER_CTL,   CFG_POWER_CTL};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_txn_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_txn_issuer
//  Description : Runs one i2c_controller transaction per request strobe:
//                latches the request, waits for ready, pulses start for one
//                cycle, then waits for finished or the timeout.
//  Ports       : clk, rst            - clock, async active-high reset
//                i_req               - one-cycle request (only while idle)
//                i_req_reg_addr/r_w/wdata - transaction to run
//                i_i2c_ready/finished/read_data - from i2c_controller
//                o_i2c_start/reg_addr/r_w/write_data - to i2c_controller
//                o_done, o_timeout   - combinational completion strobes
//                o_rdata             - read byte, valid with o_done
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_txn_issuer #(
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic [7:0] i_req_reg_addr,
    input  logic       i_req_r_w,
    input  logic [7:0] i_req_wdata,
    input  logic       i_i2c_ready,
    input  logic       i_i2c_finished,
    input  logic [7:0] i_i2c_read_data,
    output logic       o_i2c_start,
    output logic [7:0] o_i2c_reg_addr,
    output logic       o_i2c_r_w,
    output logic [7:0] o_i2c_write_data,
    output logic       o_done,
    output logic       o_timeout,
    output logic [7:0] o_rdata
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;

    // Completion is combinational so the sequencer advances on the very
    // edge that samples i2c_finished; finished beats a coinciding timeout.
    assign o_done    = (r_state == c_ST_WAIT) && i_i2c_finished;
    assign o_timeout = (r_state == c_ST_WAIT) && !i_i2c_finished && (r_cnt == c_CNT_LAST);
    assign o_rdata   = i_i2c_read_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= c_ST_IDLE;
            r_cnt            <= '0;
            o_i2c_start      <= 1'b0;
            o_i2c_reg_addr   <= 8'h00;
            o_i2c_r_w        <= 1'b1;
            o_i2c_write_data <= 8'h00;
        end else begin
            o_i2c_start <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // Address/data are held from here until the next request,
                    // which keeps them stable across the whole transaction.
                    if (i_req) begin
                        o_i2c_reg_addr   <= i_req_reg_addr;
                        o_i2c_r_w        <= i_req_r_w;
                        o_i2c_write_data <= i_req_wdata;
                        r_state          <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    if (i_i2c_ready) begin
                        o_i2c_start <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (o_done || o_timeout) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/accel_poll_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : accel_poll_sequencer
//  Description : Brings up the ADXL345 through the i2c_controller (DEVID
//                check, three config writes) and then reads DATAX0..DATAZ1
//                once per sample period, publishing a coherent X/Y/Z triple.
//  Ports       : clk, rst                 - clock, async active-high reset
//                i2c_ready/finished/read_data - from i2c_controller
//                i2c_start/dev_addr/reg_addr/r_w/write_data - to controller
//                accel_x/y/z              - signed samples {DATAn1, DATAn0}
//                sample_valid             - one-cycle new-sample pulse
//                init_done                - configuration complete
//                fault, fault_code        - sticky fault and its cause
//  Revision    : 1.0 - initial release
// ============================================================================
module accel_poll_sequencer
    import accel_pkg::*;
#(
    parameter int         SYS_CLK_SPEED  = 50000000,
    parameter int         SAMPLE_RATE_HZ = 100,
    parameter int         TIMEOUT_CYCLES = 250000,
    parameter logic [6:0] GSENSOR_ADDR   = 7'h1D,
    parameter logic [7:0] EXPECTED_DEVID = 8'hE5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i2c_ready,
    input  logic               i2c_finished,
    input  logic [7:0]         i2c_read_data,
    output logic               i2c_start,
    output logic [6:0]         i2c_dev_addr,
    output logic [7:0]         i2c_reg_addr,
    output logic               i2c_r_w,
    output logic [7:0]         i2c_write_data,
    output logic signed [15:0] accel_x,
    output logic signed [15:0] accel_y,
    output logic signed [15:0] accel_z,
    output logic               sample_valid,
    output logic               init_done,
    output logic               fault,
    output logic [1:0]         fault_code
);

    localparam logic [31:0] c_PERIOD_LAST = 32'(SYS_CLK_SPEED / SAMPLE_RATE_HZ - 1);

    accel_seq_state_e r_state;
    logic [2:0]       r_step;
    logic [31:0]      r_per_cnt;
    logic             r_per_pending;
    logic [7:0]       r_buf [0:5];

    logic             w_req;
    logic [7:0]       w_req_reg;
    logic             w_req_r_w;
    logic [7:0]       w_req_wdata;
    logic             w_done;
    logic             w_timeout;
    logic [7:0]       w_rdata;
    logic             w_period_tick;

    assign i2c_dev_addr = GSENSOR_ADDR;

    // The period counter free-runs once configured, including during reads.
    assign w_period_tick = init_done && (r_state != S_FAULT) && (r_per_cnt == c_PERIOD_LAST);

    always_comb begin
        w_req       = 1'b0;
        w_req_reg   = REG_DEVID;
        w_req_r_w   = 1'b1;
        w_req_wdata = 8'h00;
        case (r_state)
            S_ID_ISSUE: w_req = 1'b1;
            S_CFG_ISSUE: begin
                w_req                    = 1'b1;
                w_req_r_w                = 1'b0;
                {w_req_reg, w_req_wdata} = cfg_step_word(r_step);
            end
            S_RD_ISSUE: begin
                w_req     = 1'b1;
                w_req_reg = REG_DATAX0 + {5'b00000, r_step};
            end
            default: ;
        endcase
    end

    i2c_txn_issuer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_issuer (
        .clk              (clk),
        .rst              (rst),
        .i_req            (w_req),
        .i_req_reg_addr   (w_req_reg),
        .i_req_r_w        (w_req_r_w),
        .i_req_wdata      (w_req_wdata),
        .i_i2c_ready      (i2c_ready),
        .i_i2c_finished   (i2c_finished),
        .i_i2c_read_data  (i2c_read_data),
        .o_i2c_start      (i2c_start),
        .o_i2c_reg_addr   (i2c_reg_addr),
        .o_i2c_r_w        (i2c_r_w),
        .o_i2c_write_data (i2c_write_data),
        .o_done           (w_done),
        .o_timeout        (w_timeout),
        .o_rdata          (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_BOOT;
            r_step        <= 3'd0;
            r_per_cnt     <= 32'd0;
            r_per_pending <= 1'b0;
            for (int i = 0; i < 6; i++) r_buf[i] <= 8'h00;
            accel_x       <= '0;
            accel_y       <= '0;
            accel_z       <= '0;
            sample_valid  <= 1'b0;
            init_done     <= 1'b0;
            fault         <= 1'b0;
            fault_code    <= FAULT_NONE;
        end else begin
            sample_valid <= 1'b0;

            if (init_done && r_state != S_FAULT)
                r_per_cnt <= w_period_tick ? 32'd0 : r_per_cnt + 32'd1;

            // A tick that lands mid-burst is remembered once so the next burst
            // starts as soon as we are back in S_IDLE; further ticks collapse.
            if (w_period_tick && r_state != S_IDLE)
                r_per_pending <= 1'b1;

            case (r_state)
                S_BOOT:     r_state <= S_ID_ISSUE;
                S_ID_ISSUE: r_state <= S_ID_WAIT;
                S_ID_WAIT: begin
                    if (w_done) begin
                        if (w_rdata != EXPECTED_DEVID) begin
                            r_state    <= S_FAULT;
                            fault      <= 1'b1;
                            fault_code <= FAULT_DEVID;
                        end else begin
                            r_step  <= 3'd0;
                            r_state <= S_CFG_ISSUE;
                        end
                    end else if (w_timeout) begin
                        r_state    <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= FAULT_TIMEOUT;
                    end
                end
                S_CFG_ISSUE: r_state <= S_CFG_WAIT;
                S_CFG_WAIT: begin
                    if (w_done) begin
                        if (r_step == LAST_CFG_STEP) begin
                            init_done <= 1'b1;
                            r_step    <= 3'd0;
                            r_per_cnt <= 32'd0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_step  <= r_step + 3'd1;
                            r_state <= S_CFG_ISSUE;
                        end
                    end else if (w_timeout) begin
                        r_state    <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= FAULT_TIMEOUT;
                    end
                end
                S_IDLE: begin
                    if (w_period_tick || r_per_pending) begin
                        r_per_pending <= 1'b0;
                        r_step        <= 3'd0;
                        r_state       <= S_RD_ISSUE;
                    end
                end
                S_RD_ISSUE: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (w_done) begin
                        r_buf[r_step] <= w_rdata;
                        if (r_step == LAST_DATA_STEP) begin
                            r_state <= S_PUBLISH;
                        end else begin
                            r_step  <= r_step + 3'd1;
                            r_state <= S_RD_ISSUE;
                        end
                    end else if (w_timeout) begin
                        r_state    <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= FAULT_TIMEOUT;
                    end
                end
                S_PUBLISH: begin
                    // Only place the sample outputs change: X/Y/Z stay coherent.
                    accel_x      <= {r_buf[1], r_buf[0]};
                    accel_y      <= {r_buf[3], r_buf[2]};
                    accel_z      <= {r_buf[5], r_buf[4]};
                    sample_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                S_FAULT: fault <= 1'b1;
                default: r_state <= S_BOOT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accel_poll_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_accel_poll_sequencer
//  Description : Self-checking bench for accel_poll_sequencer with a small
//                i2c_controller model, a transaction scoreboard and a sample
//                scoreboard. The sample period is shortened (10 kHz at 50 MHz)
//                and the timeout scaled down to keep the run short.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_poll_sequencer;

    localparam int SYS_CLK = 50_000_000;
    localparam int RATE    = 10_000;
    localparam int TMO     = 2500;
    localparam int PERIOD  = SYS_CLK / RATE;
    localparam int LAT     = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i2c_ready = 1'b0;
    logic        i2c_finished = 1'b0;
    logic [7:0]  i2c_read_data = 8'h00;
    logic        i2c_start;
    logic [6:0]  i2c_dev_addr;
    logic [7:0]  i2c_reg_addr;
    logic        i2c_r_w;
    logic [7:0]  i2c_write_data;
    logic [15:0] accel_x, accel_y, accel_z;
    logic        sample_valid, init_done, fault;
    logic [1:0]  fault_code;

    accel_poll_sequencer #(
        .SYS_CLK_SPEED  (SYS_CLK),
        .SAMPLE_RATE_HZ (RATE),
        .TIMEOUT_CYCLES (TMO),
        .GSENSOR_ADDR   (7'h1D),
        .EXPECTED_DEVID (8'hE5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i2c_ready      (i2c_ready),
        .i2c_finished   (i2c_finished),
        .i2c_read_data  (i2c_read_data),
        .i2c_start      (i2c_start),
        .i2c_dev_addr   (i2c_dev_addr),
        .i2c_reg_addr   (i2c_reg_addr),
        .i2c_r_w        (i2c_r_w),
        .i2c_write_data (i2c_write_data),
        .accel_x        (accel_x),
        .accel_y        (accel_y),
        .accel_z        (accel_z),
        .sample_valid   (sample_valid),
        .init_done      (init_done),
        .fault          (fault),
        .fault_code     (fault_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_vec++;
        n_miss++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // ---------------------------------------------------------------- tables
    typedef struct packed {
        logic [47:0] bytes;     // {DATAZ1, DATAZ0, DATAY1, DATAY0, DATAX1, DATAX0}
        logic [15:0] x, y, z;
    } vec_t;
    typedef struct packed { logic r_w; logic [7:0] reg_a; logic [7:0] wd; } txn_t;
    typedef struct packed { logic [15:0] x, y, z; } smp_t;

    vec_t vecs [4];
    txn_t exp_q [$];
    smp_t smp_q [$];

    // --------------------------------------------------- i2c_controller model
    logic [7:0] mregs [0:63];
    bit         busy = 0;
    int         cnt_down = 0;
    logic [7:0] cur_reg = 8'h00;
    logic       cur_rw = 1'b1;
    bit         withhold_en = 0;
    int         n_starts = 0;
    int         first_start_cyc = 0;
    int         last_start_cyc = 0;
    logic [7:0] last_start_reg = 8'h00;
    int         last_fin_cyc = 0;

    initial forever begin
        @(negedge clk);
        i2c_finished = 1'b0;
        if (rst) begin
            busy = 0;
        end else begin
            if (busy) begin
                cnt_down--;
                if (cnt_down == 0) begin
                    busy = 0;
                    chk("addr_stable", {i2c_r_w, i2c_reg_addr}, {cur_rw, cur_reg});
                    if (!(withhold_en && cur_rw && cur_reg == 8'h33)) begin
                        i2c_finished  = 1'b1;
                        i2c_read_data = cur_rw ? mregs[cur_reg[5:0]] : 8'h00;
                        last_fin_cyc  = cyc;
                    end
                end
            end
            if (i2c_start) begin
                n_starts++;
                if (n_starts == 1) first_start_cyc = cyc;
                last_start_cyc = cyc;
                last_start_reg = i2c_reg_addr;
                if (!i2c_ready) fail_now("start_vs_ready", "i2c_start asserted while ready=0");
                if (busy) fail_now("start_vs_busy", "i2c_start asserted during a transaction");
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_start: reg %h r_w %b, no transaction expected (cycle %0d)",
                             i2c_reg_addr, i2c_r_w, cyc);
                    n_vec++;
                    n_miss++;
                end else begin
                    txn_t e;
                    e = exp_q.pop_front();
                    chk("txn", {i2c_r_w, i2c_dev_addr, i2c_reg_addr, (i2c_r_w ? 8'h00 : i2c_write_data)},
                               {e.r_w, 7'h1D, e.reg_a, e.wd});
                end
                busy     = 1;
                cnt_down = LAT;
                cur_reg  = i2c_reg_addr;
                cur_rw   = i2c_r_w;
            end
        end
    end

    // ------------------------------------------------------- sample monitor
    initial forever begin
        @(negedge clk);
        if (!rst && sample_valid) begin
            if (smp_q.size() == 0) begin
                fail_now("unexpected_sample", "sample_valid with no sample expected");
            end else begin
                smp_t e;
                e = smp_q.pop_front();
                chk("sample_xyz", {accel_x, accel_y, accel_z}, {e.x, e.y, e.z});
            end
            @(negedge clk);
            chk("sample_valid_pulse", {47'd0, sample_valid}, 48'd0);
        end
    end

    // --------------------------------------------------------------- helpers
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_init();
        exp_q.push_back('{1'b1, 8'h00, 8'h00});
        exp_q.push_back('{1'b0, 8'h2C, 8'h0A});
        exp_q.push_back('{1'b0, 8'h31, 8'h0B});
        exp_q.push_back('{1'b0, 8'h2D, 8'h08});
    endtask

    task automatic push_burst(input vec_t v);
        for (int b = 0; b < 6; b++) begin
            mregs[8'h32 + b] = v.bytes[8*b +: 8];
            exp_q.push_back('{1'b1, 8'(8'h32 + b), 8'h00});
        end
        smp_q.push_back('{v.x, v.y, v.z});
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_i2c_outputs"}, {i2c_start, i2c_dev_addr, i2c_reg_addr, i2c_r_w, i2c_write_data},
                                   {1'b0, 7'h1D, 8'h00, 1'b1, 8'h00});
        chk({tag, "_accel"}, {accel_x, accel_y, accel_z}, 48'd0);
        chk({tag, "_status"}, {sample_valid, init_done, fault, fault_code}, 48'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        withhold_en = 0;
        tick(2);
        exp_q.delete();
        smp_q.delete();
    endtask

    task automatic wait_init(input int limit, output int c);
        c = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (init_done) begin c = cyc; break; end
        end
        if (c < 0) fail_now("wait_init", "init_done never rose");
    endtask

    task automatic wait_fault(input int limit, output int c);
        c = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (fault) begin c = cyc; break; end
        end
        if (c < 0) fail_now("wait_fault", "fault never rose");
    endtask

    task automatic wait_sample(input int limit, output int c);
        c = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sample_valid) begin c = cyc; break; end
        end
        if (c < 0) fail_now("wait_sample", "sample_valid never pulsed");
    endtask

    task automatic wait_start_reg(input logic [7:0] r, input int limit, output bit ok);
        int s;
        s  = n_starts;
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (n_starts != s && last_start_reg == r) begin ok = 1; break; end
        end
        if (!ok) fail_now("wait_start", "expected i2c_start never seen");
    endtask

    // ------------------------------------------------------------------ test
    initial begin
        int  c, prev, t_s, s0;
        bit  ok;

        vecs[0] = '{48'h80_00_AB_CD_12_34, 16'h1234, 16'hABCD, 16'h8000};
        vecs[1] = '{48'h00_00_00_00_00_00, 16'h0000, 16'h0000, 16'h0000};
        vecs[2] = '{48'h7F_FF_00_01_FF_FF, 16'hFFFF, 16'h0001, 16'h7FFF};
        vecs[3] = '{48'hF0_0F_3C_C3_A5_5A, 16'hA55A, 16'h3CC3, 16'hF00F};
        for (int i = 0; i < 64; i++) mregs[i] = 8'h00;
        mregs[0] = 8'hE5;

        // Reset values, then ready held low for 500 cycles after release
        tick(3);
        check_reset_vals("reset");
        push_init();
        rst = 1'b0;
        tick(500);
        chk("no_start_ready_low", 48'(n_starts), 48'd0);
        i2c_ready = 1'b1;
        s0 = cyc;
        wait_init(2000, c);
        chk("first_start_after_ready", {47'd0, first_start_cyc > s0}, 48'd1);
        chk("init_done_latency", 48'(c), 48'(last_fin_cyc + 1));
        chk("init_txn_count", 48'(n_starts), 48'd4);
        chk("init_txns_consumed", 48'(exp_q.size()), 48'd0);

        // Table-driven samples; consecutive pulses must be exactly one period apart
        prev = -1;
        foreach (vecs[i]) begin
            push_burst(vecs[i]);
            wait_sample(2 * PERIOD, c);
            chk("burst_txns_consumed", 48'(exp_q.size()), 48'd0);
            if (prev >= 0 && c >= 0) chk("sample_period", 48'(c - prev), 48'(PERIOD));
            prev = c;
        end

        // Asynchronous reset while a data read is outstanding
        exp_q.push_back('{1'b1, 8'h32, 8'h00});
        exp_q.push_back('{1'b1, 8'h33, 8'h00});
        wait_start_reg(8'h33, 2 * PERIOD, ok);
        tick(10);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        tick(2);
        exp_q.delete();
        push_init();
        s0 = n_starts;
        rst = 1'b0;
        wait_init(2000, c);
        chk("reissue_after_rst", 48'(n_starts - s0), 48'd4);
        chk("reissue_txns_consumed", 48'(exp_q.size()), 48'd0);

        // DEVID mismatch: terminal fault, no further traffic
        mregs[0] = 8'hE4;
        do_reset();
        exp_q.push_back('{1'b1, 8'h00, 8'h00});
        rst = 1'b0;
        wait_fault(2000, c);
        chk("devid_fault", {init_done, fault, fault_code}, {1'b0, 1'b1, 2'd1});
        s0 = n_starts;
        tick(10000);
        chk("devid_no_more_starts", 48'(n_starts - s0), 48'd0);
        chk("devid_fault_sticky", {fault, fault_code}, {1'b1, 2'd1});

        // Timeout on the second data read after one good sample
        mregs[0] = 8'hE5;
        do_reset();
        push_init();
        rst = 1'b0;
        wait_init(2000, c);
        push_burst(vecs[0]);
        wait_sample(2 * PERIOD, c);
        withhold_en = 1;
        exp_q.push_back('{1'b1, 8'h32, 8'h00});
        exp_q.push_back('{1'b1, 8'h33, 8'h00});
        wait_start_reg(8'h33, 2 * PERIOD, ok);
        t_s = last_start_cyc;
        wait_fault(TMO + 100, c);
        chk("timeout_latency", 48'(c - t_s), 48'(TMO));
        chk("timeout_code", {init_done, fault, fault_code}, {1'b1, 1'b1, 2'd2});
        chk("timeout_holds_sample", {accel_x, accel_y, accel_z}, {16'h1234, 16'hABCD, 16'h8000});
        s0 = n_starts;
        tick(200);
        chk("timeout_no_more_starts", 48'(n_starts - s0), 48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/accel_poll_sequencer.md
Name: accel_poll_sequencer

Overview:
Sequences the existing i2c_controller to bring up the ADXL345 G-sensor and then poll acceleration continuously.
- After reset: reads DEVID, writes three configuration registers, then reads DATAX0..DATAZ1 (six single-byte reads) once per sample period.
- Publishes a coherent X/Y/Z sample to the 7-seg display path.
- Sole master of the i2c_controller request interface.

Parameters:
- SYS_CLK_SPEED, 50000000, system clock frequency in Hz.
- SAMPLE_RATE_HZ, 100, poll rate; period = SYS_CLK_SPEED/SAMPLE_RATE_HZ cycles.
- TIMEOUT_CYCLES, 250000, maximum cycles from start pulse to i2c_comms_finished (5 ms at 50 MHz).
- GSENSOR_ADDR, 7'h1D, 7-bit device address.
- EXPECTED_DEVID, 8'hE5, required DEVID value.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- i2c_ready  in  1  controller ready (i2c_controller.ready).
- i2c_finished  in  1  one-cycle done pulse (i2c_comms_finished).
- i2c_read_data  in  8  READ_DATA; valid in the i2c_finished cycle.
- i2c_start  out  1  one-cycle start_i2c_comms pulse.
- i2c_dev_addr  out  7  DEV_ADDR.
- i2c_reg_addr  out  8  REG_ADDR.
- i2c_r_w  out  1  1 = read, 0 = write.
- i2c_write_data  out  8  WRITE_DATA.
- accel_x, accel_y, accel_z  out  16 each  signed samples, {DATAn1, DATAn0}.
- sample_valid  out  1  one-cycle pulse when a new X/Y/Z triple is published.
- init_done  out  1  high after configuration completes.
- fault  out  1  sticky; set on DEVID mismatch or timeout.
- fault_code  out  2  0 none, 1 DEVID mismatch, 2 timeout.

Behaviour:
- Reset (async, rst=1) forces the following; state goes to S_BOOT.
  - All outputs 0, except i2c_dev_addr = GSENSOR_ADDR and i2c_r_w = 1.
  - Period counter, timeout counter, step index and the six-byte capture buffer cleared.
- Transaction handshake (common to all accesses):
  - Issue state: wait for i2c_ready=1. Then drive reg_addr, r_w and write_data, and assert i2c_start for exactly one cycle.
  - Address/data stay stable from the start cycle until i2c_finished.
  - Wait state: timeout counter increments each cycle.
  - i2c_finished=1: capture i2c_read_data (reads only), clear timeout, advance.
  - Counter reaches TIMEOUT_CYCLES-1 without i2c_finished: go to S_FAULT, fault_code=2.
  - i2c_finished coinciding with the timeout cycle: finished wins.
  - i2c_finished outside a wait state is ignored.
  - i2c_start is never asserted while i2c_ready=0.
- States:
  - S_BOOT: one cycle, then S_ID_ISSUE.
  - S_ID_ISSUE / S_ID_WAIT: read reg 8'h00.
    - Data != EXPECTED_DEVID: S_FAULT, fault_code=1.
    - Otherwise: S_CFG_ISSUE with step=0.
  - S_CFG_ISSUE / S_CFG_WAIT: writes in step order:
    - step 0: 8'h2C <- 8'h0A (BW_RATE 100 Hz)
    - step 1: 8'h31 <- 8'h0B (full-res ±16 g)
    - step 2: 8'h2D <- 8'h08 (measure)
    - After step 2 finishes: init_done=1 (stays high until reset), step=0, period counter=0, go to S_IDLE.
  - S_IDLE: period counter increments each cycle. At SAMPLE_RATE period-1: clear counter, go to S_RD_ISSUE, step=0.
    - The counter also runs during reads, so the period is exact as long as reads finish within one period.
    - If a read burst overruns, the next burst starts immediately on return to S_IDLE; a missed period is not queued.
  - S_RD_ISSUE / S_RD_WAIT: read reg 8'h32+step into buf[step], step 0..5.
    - After step 5: go to S_PUBLISH.
  - S_PUBLISH: one cycle.
    - accel_x={buf1,buf0}, accel_y={buf3,buf2}, accel_z={buf5,buf4}.
    - sample_valid=1 this cycle only; return to S_IDLE.
    - Outputs update only here, so the X/Y/Z triple is always coherent.
  - S_FAULT: terminal, i2c_start held 0, fault=1; leaves only via rst.
- rst mid-transaction: immediate return to reset values. The i2c_controller shares the same rst.

Decomposition:
- Shared package accel_pkg: typedef enum accel_seq_state_e; localparams for register addresses (REG_DEVID, REG_BW_RATE, REG_DATA_FORMAT, REG_POWER_CTL, REG_DATAX0) and config values; fault-code enum.
- Sub-module i2c_txn_issuer: the issue/wait/timeout handshake, taking a request strobe and returning done/timeout/rdata. Keeps the top-level FSM purely sequencing.

Test Plan:
- Bench i2c_controller model: ready=1, finished 40 cycles after start, DEVID=E5 → exactly 1 read + 3 writes in order (2C/0A, 31/0B, 2D/08); init_done rises 1 cycle after the third finished pulse.
- Model returns 8'hE4 for DEVID → fault=1, fault_code=1, no further i2c_start pulses for 10000 cycles.
- Data regs 32..37 return 34,12,CD,AB,00,80 → accel_x=16'h1234, accel_y=16'hABCD, accel_z=16'h8000; sample_valid is a single-cycle pulse.
- SAMPLE_RATE_HZ=1000 at 50 MHz → consecutive sample_valid pulses exactly 50000 cycles apart; each burst is six reads, addresses 32..37.
- Model withholds finished on the 2nd data read → fault_code=2 exactly TIMEOUT_CYCLES after that start pulse; outputs hold the last sample.
- Model holds ready=0 for 500 cycles → no i2c_start until ready=1. Separately, rst asserted mid S_RD_WAIT → all outputs return to reset values asynchronously, and the ID read reissues after release.
